// File: rtl/issue_queue_pkg.sv
// Shared types and defaults for the issue queue slice.
// ALU encodings match the dispatch/rename decode tables.
package issue_queue_pkg;
  localparam int XLEN      = 32;
  localparam int TAG_W_DEF = 6;
  localparam int ROB_W_DEF = 6;

  typedef enum logic [3:0] {
    ALU_NONE     = 4'b0000,
    ALU_OR       = 4'b0001,
    ALU_ADD      = 4'b0010,
    ALU_XOR      = 4'b0011,
    ALU_SRA      = 4'b1011,
    ALU_PASS_RHS = 4'b1111
  } alu_ctrl_e;
endpackage

// File: rtl/issue_select.sv
// Priority encoder: lowest-index asserted request wins.
// Lowest index is the oldest entry in a collapsing queue.
module issue_select #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/issue_queue.sv
// Collapsing oldest-first reservation station for one FU.
// Snoops wakeup, issues the oldest ready entry, compacts on issue.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [3:0]       alloc_ALUControl,
  input  logic             alloc_ALUSrc,
  input  logic             alloc_is_for_lsq,
  input  logic [XLEN-1:0]  alloc_imm,
  input  logic             alloc_rs1_ready,
  input  logic             alloc_rs2_ready,
  input  logic [TAG_W-1:0] alloc_rs1_tag,
  input  logic [TAG_W-1:0] alloc_rs2_tag,
  input  logic [XLEN-1:0]  alloc_rs1_value,
  input  logic [XLEN-1:0]  alloc_rs2_value,
  input  logic [TAG_W-1:0] alloc_tag_to_output,
  input  logic [ROB_W-1:0] alloc_rob_index,
  input  logic             wakeup_active,
  input  logic [TAG_W-1:0] wakeup_tag,
  input  logic [XLEN-1:0]  wakeup_value,
  input  logic             fu_is_available,
  output logic             issue_write_enable,
  output logic [3:0]       issue_ALUControl,
  output logic             issue_ALUSrc,
  output logic             issue_is_for_lsq,
  output logic [XLEN-1:0]  issue_imm,
  output logic [XLEN-1:0]  issue_rs1_value,
  output logic [XLEN-1:0]  issue_rs2_value,
  output logic [TAG_W-1:0] issue_tag_to_output,
  output logic [ROB_W-1:0] issue_rob_index
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic             valid;
    logic [3:0]       ctrl;
    logic             src;
    logic             lsq;
    logic [XLEN-1:0]  imm;
    logic             r1_rdy;
    logic [TAG_W-1:0] r1_tag;
    logic [XLEN-1:0]  r1_val;
    logic             r2_rdy;
    logic [TAG_W-1:0] r2_tag;
    logic [XLEN-1:0]  r2_val;
    logic [TAG_W-1:0] dst;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t          q     [ENTRIES];
  entry_t          q_n   [ENTRIES];
  entry_t          w     [ENTRIES];
  entry_t          cand;
  entry_t          new_raw;
  entry_t          new_e;
  logic [CW-1:0]   count;
  logic [CW-1:0]   alloc_pos;
  logic [ENTRIES-1:0] rdy;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic            alloc_fire;

  function automatic entry_t snoop(entry_t e);
    entry_t r;
    r = e;
    if (wakeup_active && e.valid) begin
      if (!e.r1_rdy && e.r1_tag == wakeup_tag) begin
        r.r1_rdy = 1'b1;
        r.r1_val = wakeup_value;
      end
      if (!e.r2_rdy && e.r2_tag == wakeup_tag) begin
        r.r2_rdy = 1'b1;
        r.r2_val = wakeup_value;
      end
    end
    return r;
  endfunction

  always_comb
    for (int i = 0; i < ENTRIES; i++)
      rdy[i] = q[i].valid & q[i].r1_rdy & q[i].r2_rdy;

  issue_select #(.N(ENTRIES), .IW(IW)) u_sel (
    .req   (rdy),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    cand = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (sel_found && int'(sel_idx) == i) cand = q[i];
  end

  assign alloc_ready        = count < CW'(ENTRIES);
  assign alloc_fire         = alloc_valid & alloc_ready;
  assign issue_write_enable = fu_is_available & sel_found;
  assign alloc_pos          = count - CW'(issue_write_enable);

  assign issue_ALUControl    = cand.ctrl;
  assign issue_ALUSrc        = cand.src;
  assign issue_is_for_lsq    = cand.lsq;
  assign issue_imm           = cand.imm;
  assign issue_rs1_value     = cand.r1_val;
  assign issue_rs2_value     = cand.r2_val;
  assign issue_tag_to_output = cand.dst;
  assign issue_rob_index     = cand.rob;

  always_comb begin
    new_raw = '{
      valid:  1'b1,
      ctrl:   alloc_ALUControl,
      src:    alloc_ALUSrc,
      lsq:    alloc_is_for_lsq,
      imm:    alloc_imm,
      r1_rdy: alloc_rs1_ready,
      r1_tag: alloc_rs1_tag,
      r1_val: alloc_rs1_value,
      r2_rdy: alloc_rs2_ready,
      r2_tag: alloc_rs2_tag,
      r2_val: alloc_rs2_value,
      dst:    alloc_tag_to_output,
      rob:    alloc_rob_index
    };
    new_e = snoop(new_raw);
  end

  // Wakeup first, then collapse over the issued slot, then append.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) w[i] = snoop(q[i]);
    for (int i = 0; i < ENTRIES; i++) q_n[i] = w[i];
    if (issue_write_enable) begin
      for (int i = 0; i < ENTRIES - 1; i++)
        if (i >= int'(sel_idx)) q_n[i] = w[i+1];
      q_n[ENTRIES-1] = '0;
    end
    if (alloc_fire)
      for (int i = 0; i < ENTRIES; i++)
        if (int'(alloc_pos) == i) q_n[i] = new_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
      count <= '0;
    end else begin
      q     <= q_n;
      count <= count + CW'(alloc_fire) - CW'(issue_write_enable);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench: directed vector table, fill/collapse
// sequences and random traffic against a queue-based model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_ALUControl;
  logic        alloc_ALUSrc, alloc_is_for_lsq;
  logic [31:0] alloc_imm;
  logic        alloc_rs1_ready, alloc_rs2_ready;
  logic [5:0]  alloc_rs1_tag, alloc_rs2_tag;
  logic [31:0] alloc_rs1_value, alloc_rs2_value;
  logic [5:0]  alloc_tag_to_output, alloc_rob_index;
  logic        wakeup_active;
  logic [5:0]  wakeup_tag;
  logic [31:0] wakeup_value;
  logic        fu_is_available;
  logic        issue_write_enable;
  logic [3:0]  issue_ALUControl;
  logic        issue_ALUSrc, issue_is_for_lsq;
  logic [31:0] issue_imm, issue_rs1_value, issue_rs2_value;
  logic [5:0]  issue_tag_to_output, issue_rob_index;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk                 (clk),
    .reset               (reset),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_ALUControl    (alloc_ALUControl),
    .alloc_ALUSrc        (alloc_ALUSrc),
    .alloc_is_for_lsq    (alloc_is_for_lsq),
    .alloc_imm           (alloc_imm),
    .alloc_rs1_ready     (alloc_rs1_ready),
    .alloc_rs2_ready     (alloc_rs2_ready),
    .alloc_rs1_tag       (alloc_rs1_tag),
    .alloc_rs2_tag       (alloc_rs2_tag),
    .alloc_rs1_value     (alloc_rs1_value),
    .alloc_rs2_value     (alloc_rs2_value),
    .alloc_tag_to_output (alloc_tag_to_output),
    .alloc_rob_index     (alloc_rob_index),
    .wakeup_active       (wakeup_active),
    .wakeup_tag          (wakeup_tag),
    .wakeup_value        (wakeup_value),
    .fu_is_available     (fu_is_available),
    .issue_write_enable  (issue_write_enable),
    .issue_ALUControl    (issue_ALUControl),
    .issue_ALUSrc        (issue_ALUSrc),
    .issue_is_for_lsq    (issue_is_for_lsq),
    .issue_imm           (issue_imm),
    .issue_rs1_value     (issue_rs1_value),
    .issue_rs2_value     (issue_rs2_value),
    .issue_tag_to_output (issue_tag_to_output),
    .issue_rob_index     (issue_rob_index)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic        src, lsq;
    logic [31:0] imm;
    logic        r1r;
    logic [5:0]  r1t;
    logic [31:0] r1v;
    logic        r2r;
    logic [5:0]  r2t;
    logic [31:0] r2v;
    logic [5:0]  dt, rob;
  } op_t;

  typedef struct {
    logic        av;
    op_t         op;
    logic        wa;
    logic [5:0]  wt;
    logic [31:0] wv;
    logic        fu;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ear, ewe;
    logic [31:0] ers1, ers2;
    logic [5:0]  etag;
  } vec_t;

  op_t   mq[$];
  int    checks = 0;
  int    fails  = 0;
  logic  d_ar, d_we;
  logic [31:0] d_rs1, d_rs2;
  logic [5:0]  d_tag;
  vec_t  tbl[21];
  op_t   z;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_t mk(logic [3:0] c, logic r1r, logic [5:0] r1t,
                             logic [31:0] r1v, logic r2r, logic [5:0] r2t,
                             logic [31:0] r2v, logic [5:0] dt,
                             logic [5:0] rob);
    op_t o;
    o.ctrl = c; o.src = 1'b0; o.lsq = 1'b0; o.imm = 32'(dt) * 7;
    o.r1r = r1r; o.r1t = r1t; o.r1v = r1v;
    o.r2r = r2r; o.r2t = r2t; o.r2v = r2v;
    o.dt = dt; o.rob = rob;
    return o;
  endfunction

  function automatic stim_t st(logic av, op_t o, logic wa, logic [5:0] wt,
                               logic [31:0] wv, logic fu);
    stim_t s;
    s.av = av; s.op = o; s.wa = wa; s.wt = wt; s.wv = wv; s.fu = fu;
    return s;
  endfunction

  function automatic vec_t row(stim_t s, logic ear, logic ewe,
                               logic [31:0] r1, logic [31:0] r2,
                               logic [5:0] t);
    vec_t v;
    v.s = s; v.ear = ear; v.ewe = ewe; v.ers1 = r1; v.ers2 = r2; v.etag = t;
    return v;
  endfunction

  function automatic op_t wake(op_t o, logic wa, logic [5:0] t,
                               logic [31:0] v);
    op_t r = o;
    if (wa && !o.r1r && o.r1t == t) begin r.r1r = 1'b1; r.r1v = v; end
    if (wa && !o.r2r && o.r2t == t) begin r.r2r = 1'b1; r.r2v = v; end
    return r;
  endfunction

  task automatic drive(input stim_t s);
    alloc_valid         = s.av;
    alloc_ALUControl    = s.op.ctrl;
    alloc_ALUSrc        = s.op.src;
    alloc_is_for_lsq    = s.op.lsq;
    alloc_imm           = s.op.imm;
    alloc_rs1_ready     = s.op.r1r;
    alloc_rs1_tag       = s.op.r1t;
    alloc_rs1_value     = s.op.r1v;
    alloc_rs2_ready     = s.op.r2r;
    alloc_rs2_tag       = s.op.r2t;
    alloc_rs2_value     = s.op.r2v;
    alloc_tag_to_output = s.op.dt;
    alloc_rob_index     = s.op.rob;
    wakeup_active       = s.wa;
    wakeup_tag          = s.wt;
    wakeup_value        = s.wv;
    fu_is_available     = s.fu;
  endtask

  // One clock: drive, sample mid-cycle, compare with model, advance model.
  task automatic step(input stim_t s);
    int  idx;
    logic m_ar, m_we;
    op_t c;
    drive(s);
    @(negedge clk);
    d_ar = alloc_ready; d_we = issue_write_enable;
    d_rs1 = issue_rs1_value; d_rs2 = issue_rs2_value;
    d_tag = issue_tag_to_output;
    m_ar = (mq.size() < N);
    idx = -1;
    for (int i = 0; i < mq.size(); i++)
      if (idx < 0 && mq[i].r1r && mq[i].r2r) idx = i;
    m_we = s.fu && (idx >= 0);
    chk("alloc_ready", alloc_ready, m_ar);
    chk("issue_we", issue_write_enable, m_we);
    chk("no_alloc_when_full", s.av & ~alloc_ready, 0);
    if (m_we) begin
      c = mq[idx];
      chk("issue_ctrl", issue_ALUControl, c.ctrl);
      chk("issue_src", issue_ALUSrc, c.src);
      chk("issue_lsq", issue_is_for_lsq, c.lsq);
      chk("issue_imm", issue_imm, c.imm);
      chk("issue_rs1", issue_rs1_value, c.r1v);
      chk("issue_rs2", issue_rs2_value, c.r2v);
      chk("issue_tag", issue_tag_to_output, c.dt);
      chk("issue_rob", issue_rob_index, c.rob);
    end
    foreach (mq[i]) mq[i] = wake(mq[i], s.wa, s.wt, s.wv);
    if (m_we) mq.delete(idx);
    if (s.av && m_ar) mq.push_back(wake(s.op, s.wa, s.wt, s.wv));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(st(1'b0, z, 1'b0, 6'd0, 32'd0, 1'b1));
    reset = 1'b1;
    #2;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_issue_we", issue_write_enable, 0);
    chk("rst_payload_rs1", issue_rs1_value, 0);
    chk("rst_payload_rs2", issue_rs2_value, 0);
    chk("rst_payload_misc",
        {issue_ALUControl, issue_ALUSrc, issue_is_for_lsq,
         issue_tag_to_output, issue_rob_index}, 0);
    chk("rst_payload_imm", issue_imm, 0);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    op_t   o;
    z = mk(4'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
    z.imm = 32'd0;
    reset = 1'b1;

    tbl[0]  = row(st(1, mk(ALU_ADD, 1, 0, 5, 1, 0, 7, 3, 2), 0, 0, 0, 1),
                  1, 0, 0, 0, 0);
    tbl[1]  = row(st(0, z, 0, 0, 0, 1), 1, 1, 5, 7, 3);
    tbl[2]  = row(st(0, z, 0, 0, 0, 1), 1, 0, 0, 0, 0);
    tbl[3]  = row(st(1, mk(ALU_OR, 0, 9, 0, 1, 0, 1, 10, 4), 0, 0, 0, 1),
                  1, 0, 0, 0, 0);
    tbl[4]  = row(st(0, z, 1, 9, 32'h10, 1), 1, 0, 0, 0, 0);
    tbl[5]  = row(st(0, z, 0, 0, 0, 1), 1, 1, 32'h10, 1, 10);
    tbl[6]  = row(st(1, mk(ALU_ADD, 1, 0, 2, 0, 4, 0, 11, 5), 1, 4, 32'h55, 1),
                  1, 0, 0, 0, 0);
    tbl[7]  = row(st(0, z, 0, 0, 0, 1), 1, 1, 2, 32'h55, 11);
    tbl[8]  = row(st(1, mk(ALU_ADD, 1, 0, 1, 1, 0, 1, 20, 6), 0, 0, 0, 0),
                  1, 0, 0, 0, 0);
    tbl[9]  = row(st(1, mk(ALU_XOR, 1, 0, 2, 1, 0, 2, 21, 7), 0, 0, 0, 0),
                  1, 0, 0, 0, 0);
    tbl[10] = row(st(0, z, 0, 0, 0, 0), 1, 0, 0, 0, 0);
    tbl[11] = row(st(0, z, 0, 0, 0, 1), 1, 1, 1, 1, 20);
    tbl[12] = row(st(0, z, 0, 0, 0, 0), 1, 0, 0, 0, 0);
    tbl[13] = row(st(0, z, 0, 0, 0, 1), 1, 1, 2, 2, 21);
    tbl[14] = row(st(0, z, 0, 0, 0, 1), 1, 0, 0, 0, 0);
    tbl[15] = row(st(1, mk(ALU_SRA, 0, 30, 0, 1, 0, 3, 40, 8), 0, 0, 0, 0),
                  1, 0, 0, 0, 0);
    tbl[16] = row(st(1, mk(ALU_OR, 1, 0, 4, 1, 0, 5, 41, 9), 0, 0, 0, 0),
                  1, 0, 0, 0, 0);
    tbl[17] = row(st(0, z, 0, 0, 0, 1), 1, 1, 4, 5, 41);
    tbl[18] = row(st(0, z, 1, 30, 32'h77, 1), 1, 0, 0, 0, 0);
    tbl[19] = row(st(0, z, 0, 0, 0, 1), 1, 1, 32'h77, 3, 40);
    tbl[20] = row(st(0, z, 0, 0, 0, 1), 1, 0, 0, 0, 0);

    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].s);
      chk($sformatf("tbl%0d_ar", i), d_ar, tbl[i].ear);
      chk($sformatf("tbl%0d_we", i), d_we, tbl[i].ewe);
      if (tbl[i].ewe) begin
        chk($sformatf("tbl%0d_rs1", i), d_rs1, tbl[i].ers1);
        chk($sformatf("tbl%0d_rs2", i), d_rs2, tbl[i].ers2);
        chk($sformatf("tbl%0d_tag", i), d_tag, tbl[i].etag);
      end
    end

    // Fill, issue while full, refill, then drain in order.
    for (int i = 0; i < N; i++) begin
      step(st(1, mk(ALU_ADD, 1, 0, 32'(i), 1, 0, 32'(i + 100),
                    6'(i + 1), 6'(i)), 0, 0, 0, 0));
      chk("fill_ar", d_ar, 1);
    end
    step(st(0, z, 0, 0, 0, 0));
    chk("full_ar", d_ar, 0);
    step(st(0, z, 0, 0, 0, 1));
    chk("full_issue_ar", d_ar, 0);
    chk("full_issue_we", d_we, 1);
    chk("full_issue_tag", d_tag, 1);
    step(st(1, mk(ALU_PASS_RHS, 1, 0, 9, 1, 0, 9, 50, 50), 0, 0, 0, 0));
    chk("reopen_ar", d_ar, 1);
    step(st(0, z, 0, 0, 0, 0));
    chk("refull_ar", d_ar, 0);
    for (int k = 0; k < N; k++) begin
      step(st(0, z, 0, 0, 0, 1));
      chk("drain_we", d_we, 1);
      chk("drain_tag", d_tag, (k < N - 1) ? k + 2 : 50);
    end
    step(st(0, z, 0, 0, 0, 1));
    chk("drained_we", d_we, 0);

    // Random traffic with small tag space to force wakeup matches.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      o.ctrl = 4'($urandom_range(0, 15));
      o.src  = 1'($urandom_range(0, 1));
      o.lsq  = 1'($urandom_range(0, 1));
      o.imm  = $urandom;
      o.r1r  = 1'($urandom_range(0, 1));
      o.r1t  = 6'($urandom_range(0, 7));
      o.r1v  = $urandom;
      o.r2r  = 1'($urandom_range(0, 1));
      o.r2t  = 6'($urandom_range(0, 7));
      o.r2v  = $urandom;
      o.dt   = 6'($urandom_range(0, 63));
      o.rob  = 6'($urandom_range(0, 63));
      s = st(($urandom_range(0, 99) < 55) && (mq.size() < N), o,
             $urandom_range(0, 99) < 40, 6'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 99) < 50);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
